// File: rtl/soc_mem_pkg.sv
// soc_mem_pkg: shared types, address defaults and MMIO map for the data-memory responder
package soc_mem_pkg;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_RSV} size_e;
  localparam logic [31:0] DRAM_BASE_D = 32'h8010_0000;
  localparam logic [31:0] MMIO_BASE_D = 32'h8020_0000;
  localparam logic [7:0] OFF_SW = 8'h00;
  localparam logic [7:0] OFF_SEG = 8'h20;
  localparam logic [7:0] OFF_LED = 8'h40;
  localparam logic [7:0] OFF_TCTL = 8'h50;
  localparam logic [7:0] OFF_TVAL = 8'h54;
  function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~m) | (nw & m);
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane steering, store legality and load right-alignment
module mem_lane_align
  import soc_mem_pkg::*;
(
  input  logic [1:0]  off,
  input  size_e       size,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        legal
);
  assign legal = size == SZ_B || (size == SZ_H && !off[0]) || (size == SZ_W && off == 2'd0);
  assign be = !legal ? 4'b0000 : size == SZ_B ? 4'b0001 << off : size == SZ_H ? 4'b0011 << off : 4'b1111;
  assign wword = wdata << {off, 3'b000};
  assign rdata = rword >> {off, 3'b000};
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: LSU-facing data RAM plus LED/7-seg/switch/timer MMIO registers
module dmem_responder
  import soc_mem_pkg::*;
#(
  parameter logic [31:0] DRAM_BASE = DRAM_BASE_D,
  parameter int          DRAM_AW   = 14,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_D,
  parameter int          TICK_DIV  = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        wen,
  input  logic [31:0] wdata,
  input  logic [1:0]  mask,
  output logic [31:0] rdata,
  input  logic [31:0] sw,
  output logic [31:0] led,
  output logic [31:0] seg,
  output logic [7:0]  err_cnt
);
  localparam logic [31:0] TDM1 = 32'(TICK_DIV - 1);
  logic [31:0] mem [2**DRAM_AW];
  logic [31:0] tval, presc, rword, wword, mmio_rd;
  logic [3:0] be;
  logic [7:0] reg_off;
  logic [DRAM_AW-1:0] widx;
  logic run, legal, ram_hit, mmio_hit, known, drop, wr_ok, mmio_we, tick;
  mem_lane_align u_align (
    .off(addr[1:0]),
    .size(size_e'(mask)),
    .wdata(wdata),
    .rword(rword),
    .be(be),
    .wword(wword),
    .rdata(rdata),
    .legal(legal)
  );
  assign widx = addr[DRAM_AW+1:2];
  assign reg_off = {addr[7:2], 2'b00};
  assign tick = run && presc == TDM1;
  always_comb begin
    ram_hit = addr[31:DRAM_AW+2] == DRAM_BASE[31:DRAM_AW+2];
    mmio_hit = addr[31:8] == MMIO_BASE[31:8];
    known = reg_off inside {OFF_SW, OFF_SEG, OFF_LED, OFF_TCTL, OFF_TVAL};
    mmio_rd = reg_off == OFF_SW ? sw :
              reg_off == OFF_SEG ? seg :
              reg_off == OFF_LED ? led :
              reg_off == OFF_TCTL ? {31'b0, run} :
              reg_off == OFF_TVAL ? tval : 32'b0;
    rword = ram_hit ? mem[widx] : mmio_hit ? mmio_rd : 32'b0;
    drop = wen && !(legal && (ram_hit || (mmio_hit && known)));
    wr_ok = wen && !drop;
    mmio_we = wr_ok && mmio_hit;
  end
  always_ff @(posedge clock) begin
    if (!reset && wr_ok && ram_hit)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[widx][8*i +: 8] <= wword[8*i +: 8];
  end
  // SW and TVAL writes are accepted but change nothing; TCTL writes restart the timer
  always_ff @(posedge clock) begin
    if (reset) begin
      led <= '0;
      seg <= '0;
      err_cnt <= '0;
      run <= 1'b0;
      tval <= '0;
      presc <= '0;
    end else begin
      if (mmio_we && reg_off == OFF_SEG) seg <= merge_be(seg, wword, be);
      if (mmio_we && reg_off == OFF_LED) led <= merge_be(led, wword, be);
      if (mmio_we && reg_off == OFF_TCTL) begin
        run <= be[0] ? wword[0] : run;
        presc <= '0;
        tval <= '0;
      end else if (run) begin
        presc <= tick ? 32'b0 : presc + 32'd1;
        tval <= tval + {31'b0, tick};
      end
      if (drop && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
endmodule
